// File: rtl/lfsr_prbs_checker_if.sv
// Stream and status interface for lfsr_prbs_checker.
// LFSR_CHK_STATS_EN adds the word_count status signal.
interface lfsr_prbs_checker_if #(
  parameter int ERR_W = 16
);
  logic             in_valid;
  logic [15:0]      in_data;
  logic             clr;
  logic             locked;
  logic             err_pulse;
  logic [ERR_W-1:0] err_count;
`ifdef LFSR_CHK_STATS_EN
  logic [31:0]      word_count;
`endif

  // master drives the stream, slave is the checker
  modport master (
    output in_valid, in_data, clr,
`ifdef LFSR_CHK_STATS_EN
    input  word_count,
`endif
    input  locked, err_pulse, err_count
  );

  modport slave (
    input  in_valid, in_data, clr,
`ifdef LFSR_CHK_STATS_EN
    output word_count,
`endif
    output locked, err_pulse, err_count
  );
endinterface

// File: rtl/lfsr_prbs_checker.sv
// Receive-side checker for the 16-bit LFSR word stream (taps 11,13,14,16,
// 16 shifts per word). Hunts for sync by seeding from received words, then
// flywheels its own prediction while LOCKED and counts word errors.
// Optional feature macro: LFSR_CHK_STATS_EN adds a 32-bit LOCKED word counter.
//
//   state  | meaning
//   HUNT   | seeding from received words, counting consecutive correct predictions
//   LOCKED | flywheeling prediction, counting word errors and consecutive misses
module lfsr_prbs_checker #(
  parameter int LOCK_COUNT    = 4,
  parameter int UNLOCK_THRESH = 3,
  parameter int ERR_W         = 16
) (
  input logic                 clk,
  input logic                 rst_n,
  lfsr_prbs_checker_if.slave  bus
);

  typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam int UW = $clog2(UNLOCK_THRESH + 1);
  localparam logic [MW:0] LOCK_TGT   = (MW + 1)'(LOCK_COUNT);
  localparam logic [UW:0] UNLOCK_TGT = (UW + 1)'(UNLOCK_THRESH);

  // Sixteen Fibonacci shifts, unrolled into pure combinational logic.
  function automatic logic [15:0] lfsr_next(input logic [15:0] x);
    logic [15:0] s;
    s = x;
    for (int i = 0; i < 16; i++) begin
      s = {s[14:0], s[10] ^ s[12] ^ s[13] ^ s[15]};
    end
    return s;
  endfunction

  state_t            state_q, state_d;
  logic [15:0]       pred_q, pred_d;
  logic              seeded_q, seeded_d;
  logic [MW-1:0]     match_q, match_d;
  logic [UW-1:0]     miss_q, miss_d;
  logic [MW:0]       match_inc;
  logic [UW:0]       miss_inc;
  logic              word_err;
  logic              err_pulse_q;
  logic [ERR_W-1:0]  err_count_q;

  assign match_inc = {1'b0, match_q} + 1'b1;
  assign miss_inc  = {1'b0, miss_q} + 1'b1;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= HUNT;
    else        state_q <= state_d;
  end

  // Next-state and sync-tracking decisions for the current word
  always_comb begin
    state_d  = state_q;
    pred_d   = pred_q;
    seeded_d = seeded_q;
    match_d  = match_q;
    miss_d   = miss_q;
    word_err = 1'b0;
    if (bus.in_valid) begin
      case (state_q)
        HUNT: begin
          if (bus.in_data == 16'h0000) begin
            // all-zero word can never appear in the stream; drop the seed
            seeded_d = 1'b0;
            match_d  = '0;
          end else if (seeded_q && (bus.in_data == pred_q)) begin
            pred_d  = lfsr_next(bus.in_data);
            match_d = match_inc[MW-1:0];
            if (match_inc == LOCK_TGT) begin
              state_d = LOCKED;
              miss_d  = '0;
            end
          end else begin
            pred_d   = lfsr_next(bus.in_data);
            seeded_d = 1'b1;
            match_d  = '0;
          end
        end
        LOCKED: begin
          // received data never reseeds once locked
          pred_d = lfsr_next(pred_q);
          if (bus.in_data == pred_q) begin
            miss_d = '0;
          end else begin
            word_err = 1'b1;
            miss_d   = miss_inc[UW-1:0];
            if (miss_inc == UNLOCK_TGT) begin
              state_d  = HUNT;
              seeded_d = 1'b0;
              match_d  = '0;
            end
          end
        end
      endcase
    end
  end

  // Prediction and sync counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred_q   <= 16'h0000;
      seeded_q <= 1'b0;
      match_q  <= '0;
      miss_q   <= '0;
    end else begin
      pred_q   <= pred_d;
      seeded_q <= seeded_d;
      match_q  <= match_d;
      miss_q   <= miss_d;
    end
  end

  // Error pulse and saturating error counter; clr wins over a coincident error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      err_pulse_q <= word_err;
      if (bus.clr)
        err_count_q <= '0;
      else if (word_err && !(&err_count_q))
        err_count_q <= err_count_q + 1'b1;
    end
  end

`ifdef LFSR_CHK_STATS_EN
  logic [31:0] word_count_q;

  // Count every valid word seen while LOCKED, wrapping naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      word_count_q <= 32'd0;
    else if (bus.clr)
      word_count_q <= 32'd0;
    else if (bus.in_valid && (state_q == LOCKED))
      word_count_q <= word_count_q + 32'd1;
  end

  assign bus.word_count = word_count_q;
`endif

  assign bus.locked    = (state_q == LOCKED);
  assign bus.err_pulse = err_pulse_q;
  assign bus.err_count = err_count_q;

endmodule

// File: tb/tb_lfsr_prbs_checker.sv
// Directed bench for lfsr_prbs_checker (LOCK_COUNT=2, UNLOCK_THRESH=3, ERR_W=2).
module tb_lfsr_prbs_checker;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  logic [15:0] cur;

  lfsr_prbs_checker_if #(.ERR_W(2)) bus ();

  lfsr_prbs_checker #(
    .LOCK_COUNT(2),
    .UNLOCK_THRESH(3),
    .ERR_W(2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] model_next(input logic [15:0] x);
    logic [15:0] s;
    logic fb;
    s = x;
    for (int i = 0; i < 16; i++) begin
      fb = s[10] ^ s[12] ^ s[13] ^ s[15];
      s  = {s[14:0], fb};
    end
    return s;
  endfunction

  // drive one cycle of inputs; outputs for that word are visible on return
  task automatic step(input logic v, input logic [15:0] d, input logic c);
    @(negedge clk);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.clr      = c;
    @(posedge clk);
    #1;
  endtask

  task automatic good_word();
    cur = model_next(cur);
    step(1'b1, cur, 1'b0);
  endtask

  task automatic bad_word(input logic c);
    cur = model_next(cur);
    step(1'b1, cur ^ 16'h0001, c);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 16'h0000;
    bus.clr      = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    total++;
    if (bus.locked !== 1'b0 || bus.err_pulse !== 1'b0 || bus.err_count !== 2'd0) begin
      bad++;
      $display("FAIL reset_outputs: got locked=%b pulse=%b cnt=%0d want 0/0/0",
               bus.locked, bus.err_pulse, bus.err_count);
    end
`ifdef LFSR_CHK_STATS_EN
    total++;
    if (bus.word_count !== 32'd0) begin
      bad++;
      $display("FAIL reset_word_count: got %0d want 0", bus.word_count);
    end
`endif
  endtask

  task automatic test_lock();
    step(1'b1, 16'hFFFF, 1'b0);
    step(1'b1, 16'h001B, 1'b0);
    total++;
    if (bus.locked !== 1'b0) begin
      bad++;
      $display("FAIL lock_early: got locked=%b want 0 after 001B", bus.locked);
    end
    step(1'b1, 16'h03CF, 1'b0);
    cur = 16'h03CF;
    total++;
    if (bus.locked !== 1'b1 || bus.err_count !== 2'd0) begin
      bad++;
      $display("FAIL lock_golden: got locked=%b cnt=%0d want 1/0", bus.locked, bus.err_count);
    end
  endtask

  task automatic test_single_error();
    good_word();
    good_word();
    total++;
    if (bus.err_pulse !== 1'b0 || bus.locked !== 1'b1) begin
      bad++;
      $display("FAIL clean_locked: got pulse=%b locked=%b want 0/1", bus.err_pulse, bus.locked);
    end
    bad_word(1'b0);
    total++;
    if (bus.err_pulse !== 1'b1 || bus.err_count !== 2'd1 || bus.locked !== 1'b1) begin
      bad++;
      $display("FAIL single_err: got pulse=%b cnt=%0d locked=%b want 1/1/1",
               bus.err_pulse, bus.err_count, bus.locked);
    end
    good_word();
    total++;
    if (bus.err_pulse !== 1'b0 || bus.err_count !== 2'd1 || bus.locked !== 1'b1) begin
      bad++;
      $display("FAIL flywheel_after_err: got pulse=%b cnt=%0d locked=%b want 0/1/1",
               bus.err_pulse, bus.err_count, bus.locked);
    end
    step(1'b0, 16'h0000, 1'b0);
    good_word();
    total++;
    if (bus.err_pulse !== 1'b0 || bus.err_count !== 2'd1) begin
      bad++;
      $display("FAIL gap_then_clean: got pulse=%b cnt=%0d want 0/1", bus.err_pulse, bus.err_count);
    end
  endtask

  task automatic test_unlock();
    step(1'b0, 16'h0000, 1'b1);
    total++;
    if (bus.err_count !== 2'd0 || bus.locked !== 1'b1) begin
      bad++;
      $display("FAIL clr_only: got cnt=%0d locked=%b want 0/1", bus.err_count, bus.locked);
    end
    for (int i = 1; i <= 3; i++) begin
      bad_word(1'b0);
      total++;
      if (bus.err_count !== 2'(i) || bus.locked !== (i < 3)) begin
        bad++;
        $display("FAIL unlock_miss%0d: got cnt=%0d locked=%b want %0d/%b",
                 i, bus.err_count, bus.locked, i, (i < 3));
      end
    end
    for (int i = 1; i <= 3; i++) begin
      good_word();
      total++;
      if (bus.locked !== (i == 3) || bus.err_pulse !== 1'b0 || bus.err_count !== 2'd3) begin
        bad++;
        $display("FAIL relock_word%0d: got locked=%b pulse=%b cnt=%0d want %b/0/3",
                 i, bus.locked, bus.err_pulse, bus.err_count, (i == 3));
      end
    end
  endtask

  task automatic test_saturate();
    int exp_cnt;
    step(1'b0, 16'h0000, 1'b1);
    for (int n = 1; n <= 5; n++) begin
      bad_word(1'b0);
      exp_cnt = (n > 3) ? 3 : n;
      total++;
      if (bus.err_count !== 2'(exp_cnt) || bus.err_pulse !== 1'b1) begin
        bad++;
        $display("FAIL sat_err%0d: got cnt=%0d pulse=%b want %0d/1",
                 n, bus.err_count, bus.err_pulse, exp_cnt);
      end
      good_word();
    end
    bad_word(1'b1);
    total++;
    if (bus.err_count !== 2'd0 || bus.err_pulse !== 1'b1 || bus.locked !== 1'b1) begin
      bad++;
      $display("FAIL clr_vs_err: got cnt=%0d pulse=%b locked=%b want 0/1/1",
               bus.err_count, bus.err_pulse, bus.locked);
    end
    good_word();
    total++;
    if (bus.err_count !== 2'd0 || bus.err_pulse !== 1'b0) begin
      bad++;
      $display("FAIL after_clr: got cnt=%0d pulse=%b want 0/0", bus.err_count, bus.err_pulse);
    end
  endtask

  task automatic test_hunt_zeros();
    do_reset();
    step(1'b1, 16'h0000, 1'b0);
    step(1'b0, 16'h0000, 1'b0);
    step(1'b1, 16'h0000, 1'b0);
    step(1'b1, 16'hFFFF, 1'b0);
    step(1'b0, 16'h1234, 1'b0);
    step(1'b0, 16'h0000, 1'b0);
    step(1'b1, 16'h001B, 1'b0);
    total++;
    if (bus.locked !== 1'b0) begin
      bad++;
      $display("FAIL zeros_early: got locked=%b want 0", bus.locked);
    end
    step(1'b0, 16'h03CF, 1'b0);
    step(1'b1, 16'h03CF, 1'b0);
    total++;
    if (bus.locked !== 1'b1 || bus.err_count !== 2'd0) begin
      bad++;
      $display("FAIL zeros_gaps_lock: got locked=%b cnt=%0d want 1/0", bus.locked, bus.err_count);
    end
    // a zero between seed and match discards the seed
    do_reset();
    step(1'b1, 16'hFFFF, 1'b0);
    step(1'b1, 16'h0000, 1'b0);
    step(1'b1, 16'h001B, 1'b0);
    step(1'b1, 16'h03CF, 1'b0);
    total++;
    if (bus.locked !== 1'b0) begin
      bad++;
      $display("FAIL zero_unseeds: got locked=%b want 0", bus.locked);
    end
    cur = 16'h03CF;
    good_word();
    total++;
    if (bus.locked !== 1'b1) begin
      bad++;
      $display("FAIL zero_unseeds_lock: got locked=%b want 1", bus.locked);
    end
    // mismatches while hunting are silent
    do_reset();
    step(1'b1, 16'hFFFF, 1'b0);
    step(1'b1, 16'h1234, 1'b0);
    total++;
    if (bus.err_pulse !== 1'b0 || bus.err_count !== 2'd0 || bus.locked !== 1'b0) begin
      bad++;
      $display("FAIL hunt_silent: got pulse=%b cnt=%0d locked=%b want 0/0/0",
               bus.err_pulse, bus.err_count, bus.locked);
    end
  endtask

  task automatic test_reset_mid_locked();
    do_reset();
    step(1'b1, 16'hFFFF, 1'b0);
    step(1'b1, 16'h001B, 1'b0);
    step(1'b1, 16'h03CF, 1'b0);
    cur = 16'h03CF;
    good_word();
    bad_word(1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    total++;
    if (bus.locked !== 1'b0 || bus.err_pulse !== 1'b0 || bus.err_count !== 2'd0) begin
      bad++;
      $display("FAIL async_reset: got locked=%b pulse=%b cnt=%0d want 0/0/0",
               bus.locked, bus.err_pulse, bus.err_count);
    end
`ifdef LFSR_CHK_STATS_EN
    total++;
    if (bus.word_count !== 32'd0) begin
      bad++;
      $display("FAIL async_reset_wc: got %0d want 0", bus.word_count);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 16'hFFFF, 1'b0);
    step(1'b1, 16'h001B, 1'b0);
    step(1'b1, 16'h03CF, 1'b0);
    cur = 16'h03CF;
    total++;
    if (bus.locked !== 1'b1) begin
      bad++;
      $display("FAIL relock_after_reset: got locked=%b want 1", bus.locked);
    end
`ifdef LFSR_CHK_STATS_EN
    total++;
    if (bus.word_count !== 32'd0) begin
      bad++;
      $display("FAIL wc_hunt_words: got %0d want 0", bus.word_count);
    end
    good_word();
    bad_word(1'b0);
    total++;
    if (bus.word_count !== 32'd2) begin
      bad++;
      $display("FAIL wc_locked_words: got %0d want 2", bus.word_count);
    end
    step(1'b1, model_next(cur), 1'b1);
    cur = model_next(cur);
    total++;
    if (bus.word_count !== 32'd0) begin
      bad++;
      $display("FAIL wc_clr: got %0d want 0", bus.word_count);
    end
`endif
  endtask

  initial begin
    total = 0;
    bad   = 0;
    cur   = 16'hFFFF;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 16'h0000;
    bus.clr      = 1'b0;
    test_reset();
    test_lock();
    test_single_error();
    test_unlock();
    test_saturate();
    test_hunt_zeros();
    test_reset_mid_locked();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
